// File: rtl/cbus_ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// cbus_ram_responder_pkg
// Shared types and constants for the CBus RAM responder slice:
//   - mlen_t / MLEN*          : burst length encoding (MLENn == n-1)
//   - AXI_BURST_*             : burst type encoding
//   - cbus_req_t / cbus_resp_t: request and response bundles
//   - cbus_ram_state_t        : responder FSM states
//   - CBUS_OOR_PATTERN        : data returned for out-of-range beats
//   - mlen_to_beats()         : length code to beat count (1..16)
// -----------------------------------------------------------------------------
package cbus_ram_responder_pkg;

    typedef logic [3:0] mlen_t;

    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [63:0] CBUS_OOR_PATTERN = 64'hdead_beef_dead_beef;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } cbus_ram_state_t;

    // Beat count of a transaction: MLEN1..MLEN16 map to 1..16.
    function automatic logic [4:0] mlen_to_beats(input mlen_t len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/cbus_ram_responder_if.sv
// -----------------------------------------------------------------------------
// cbus_ram_responder_if
// CBus request/response bundle between an initiator and the RAM responder.
//   req  : cbus_req_t,  driven by the initiator (master)
//   resp : cbus_resp_t, driven by the responder (slave)
// -----------------------------------------------------------------------------
interface cbus_ram_responder_if;
    import cbus_ram_responder_pkg::*;

    cbus_req_t  req;
    cbus_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/cbus_ram_responder_array.sv
// -----------------------------------------------------------------------------
// cbus_ram_array
// MEM_WORDS x 64-bit storage with one asynchronous read port and one
// byte-strobed synchronous write port sharing a single word address.
// Contents are never cleared.
// Ports:
//   clk    in  clock
//   we     in  write enable for this cycle
//   addr   in  word index (read and write)
//   strobe in  byte lanes to write
//   wdata  in  write data
//   rdata  out combinational read of word addr (pre-write value)
// -----------------------------------------------------------------------------
module cbus_ram_array #(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       strobe,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem_r [MEM_WORDS];

    // Byte-lane write port: only strobed lanes of the addressed word change.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we && strobe[i]) begin
                mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/cbus_ram_responder.sv
// -----------------------------------------------------------------------------
// cbus_ram_responder
// Memory-side CBus responder. Accepts single/burst read/write requests and
// returns one response beat per cycle from an internal 64-bit RAM after
// LATENCY idle cycles.
// Parameters:
//   MEM_WORDS  depth in 64-bit words (power of two)
//   BASE_ADDR  physical address of word 0
//   LATENCY    idle cycles between acceptance and first beat (0..15)
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-low reset
//   bus    slave modport: req in (cbus_req_t), resp out (cbus_resp_t)
//   oor    out  out-of-range indication, one pulse per beat
// Build option:
//   CBUS_RAM_OOR_CHECK_EN  when defined, a request whose offset from BASE_ADDR
//   is beyond the RAM returns CBUS_OOR_PATTERN, writes nothing and raises oor
//   with every beat. Otherwise addresses alias modulo MEM_WORDS and oor is 0.
// -----------------------------------------------------------------------------
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cbus_ram_responder_if.slave  bus,
    output logic                 oor
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;

    cbus_ram_state_t  state_r;
    cbus_ram_state_t  state_next_s;

    logic [3:0]       lat_cnt_r;
    logic [3:0]       beat_cnt_r;
    logic [3:0]       last_idx_r;
    logic [IDX_W-1:0] word_r;
    logic             is_write_r;
    logic [1:0]       burst_r;
    logic             oor_r;

    logic [63:0]      off_s;
    logic [IDX_W-1:0] req_word_s;
    logic             req_oor_s;
    logic             last_beat_s;
    logic             ram_we_s;
    logic [63:0]      ram_rdata_s;
    cbus_resp_t       resp_s;
    logic             oor_s;
    logic             unused_s;

    // Byte offset from the RAM base; word select ignores addr[2:0] and
    // anything above the RAM depth.
    assign off_s      = bus.req.addr - BASE_ADDR;
    assign req_word_s = off_s[IDX_W+2:3];

`ifdef CBUS_RAM_OOR_CHECK_EN
    assign req_oor_s = (off_s >= MEM_BYTES);
`else
    assign req_oor_s = 1'b0;
`endif

    assign last_beat_s = (beat_cnt_r == last_idx_r);

    // size carries no addressing meaning here; strobes select the lanes.
    assign unused_s = ^{bus.req.size, off_s[2:0], off_s[63:IDX_W+3], MEM_BYTES[0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; valid is only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req.valid) begin
                    if (LAT_INIT == 4'd0) begin
                        state_next_s = BEAT;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (lat_cnt_r <= 4'd1) begin
                    state_next_s = BEAT;
                end else begin
                    state_next_s = WAIT;
                end
            end
            BEAT: begin
                if (last_beat_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BEAT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Transaction context and counters: latched at acceptance, stepped per beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt_r  <= 4'd0;
            beat_cnt_r <= 4'd0;
            last_idx_r <= 4'd0;
            word_r     <= '0;
            is_write_r <= 1'b0;
            burst_r    <= 2'b00;
            oor_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req.valid) begin
                        lat_cnt_r  <= LAT_INIT;
                        beat_cnt_r <= 4'd0;
                        last_idx_r <= 4'(mlen_to_beats(bus.req.len) - 5'd1);
                        word_r     <= req_word_s;
                        is_write_r <= bus.req.is_write;
                        burst_r    <= bus.req.burst;
                        oor_r      <= req_oor_s;
                    end
                end
                WAIT: begin
                    lat_cnt_r <= lat_cnt_r - 4'd1;
                end
                BEAT: begin
                    if (last_beat_s) begin
                        beat_cnt_r <= 4'd0;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                    end
                    // Word index is IDX_W bits wide, so INCR wraps at the top of the RAM.
                    if (burst_r == AXI_BURST_INCR) begin
                        word_r <= word_r + 1'b1;
                    end
                end
                default: begin
                    lat_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // FSM outputs: one response beat per BEAT cycle, quiet during reset.
    always_comb begin
        resp_s   = '0;
        oor_s    = 1'b0;
        ram_we_s = 1'b0;
        if (reset && (state_r == BEAT)) begin
            resp_s.ready = 1'b1;
            resp_s.last  = last_beat_s;
            if (oor_r) begin
                resp_s.data = CBUS_OOR_PATTERN;
                oor_s       = 1'b1;
            end else begin
                resp_s.data = ram_rdata_s;
                ram_we_s    = is_write_r;
            end
        end else begin
            resp_s   = '0;
            oor_s    = 1'b0;
            ram_we_s = 1'b0;
        end
    end

    assign bus.resp = resp_s;
    assign oor      = oor_s;

    cbus_ram_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (ram_we_s),
        .addr   (word_r),
        .strobe (bus.req.strobe),
        .wdata  (bus.req.data),
        .rdata  (ram_rdata_s)
    );

endmodule

// File: tb/tb_cbus_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_cbus_ram_responder
// Self-checking bench: an initiator drives directed and random CBus
// transactions; a word-array reference model predicts every response cycle.
// -----------------------------------------------------------------------------
module tb_cbus_ram_responder;
    import cbus_ram_responder_pkg::*;

    localparam int          MEM_WORDS = 4096;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          LAT       = 2;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

    logic clk = 1'b0;
    logic reset;
    logic oor;

    cbus_ram_responder_if bus ();

    cbus_ram_responder #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .oor   (oor)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] ref_mem [MEM_WORDS];
    logic [63:0] txn_data [16];
    logic [7:0]  txn_strb [16];

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction, entered and left just after a rising edge.
    // abort_at >= 0 pulls reset during that beat index (reads only).
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int abort_at);
        logic [63:0] off;
        logic [63:0] exp_d;
        int          w;
        int          beats;
        logic        oor_exp;
        off   = addr - BASE;
        w     = int'((off >> 3) % 64'(MEM_WORDS));
        beats = int'(len) + 1;
`ifdef CBUS_RAM_OOR_CHECK_EN
        oor_exp = (off >= MEM_BYTES);
`else
        oor_exp = 1'b0;
`endif
        bus.req.valid    = 1'b1;
        bus.req.is_write = wr;
        bus.req.size     = 3'd3;
        bus.req.addr     = addr;
        bus.req.strobe   = txn_strb[0];
        bus.req.data     = txn_data[0];
        bus.req.len      = len;
        bus.req.burst    = burst;
        @(posedge clk);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check_val("wait_quiet", {bus.resp, oor}, 80'd0);
        end
        for (int b = 0; b < beats; b++) begin
            @(negedge clk);
            exp_d = oor_exp ? 64'hdead_beef_dead_beef : ref_mem[w];
            check_val("ready", bus.resp.ready, 1'b1);
            check_val("last", bus.resp.last, (b == beats - 1));
            check_val("data", bus.resp.data, exp_d);
            check_val("oor", oor, oor_exp);
            if (b == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check_val("abort_quiet", {bus.resp, oor}, 80'd0);
                @(posedge clk);
                #1;
                reset   = 1'b1;
                bus.req = '0;
                @(negedge clk);
                check_val("abort_idle", {bus.resp, oor}, 80'd0);
                @(posedge clk);
                #1;
                return;
            end
            if (wr && !oor_exp) begin
                for (int i = 0; i < 8; i++) begin
                    if (txn_strb[b][i]) ref_mem[w][i*8 +: 8] = txn_data[b][i*8 +: 8];
                end
            end
            @(posedge clk);
            #1;
            if (b < beats - 1) begin
                bus.req.data   = txn_data[b+1];
                bus.req.strobe = txn_strb[b+1];
            end else begin
                bus.req = '0;
            end
            if (burst == AXI_BURST_INCR) w = (w + 1) % MEM_WORDS;
        end
        @(negedge clk);
        check_val("idle_after", {bus.resp, oor}, 80'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input logic [7:0] strb);
        for (int i = 0; i < 16; i++) begin
            txn_data[i] = {$urandom, $urandom};
            txn_strb[i] = strb;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        int          r;
        reset   = 1'b0;
        bus.req = '0;
        for (int i = 0; i < 16; i++) begin
            txn_data[i] = 64'd0;
            txn_strb[i] = 8'hFF;
        end
        repeat (3) begin
            @(negedge clk);
            check_val("reset_quiet", {bus.resp, oor}, 80'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < MEM_WORDS / 16; i++) begin
            fill_random(8'hFF);
            run_txn(1'b1, BASE + 64'(i) * 64'd128, MLEN16, AXI_BURST_INCR, -1);
        end

        // Single read of a known word.
        txn_data[0] = 64'h1122_3344_5566_7788;
        txn_strb[0] = 8'hFF;
        run_txn(1'b1, BASE, MLEN1, AXI_BURST_INCR, -1);
        run_txn(1'b0, BASE, MLEN1, AXI_BURST_INCR, -1);

        // Four-beat INCR write then read back.
        for (int i = 0; i < 4; i++) begin
            txn_data[i] = 64'(i + 1);
            txn_strb[i] = 8'hFF;
        end
        run_txn(1'b1, BASE + 64'd8, MLEN4, AXI_BURST_INCR, -1);
        run_txn(1'b0, BASE + 64'd8, MLEN4, AXI_BURST_INCR, -1);

        // Partial-strobe write over a zero word.
        txn_data[0] = 64'd0;
        txn_strb[0] = 8'hFF;
        run_txn(1'b1, BASE, MLEN1, AXI_BURST_INCR, -1);
        txn_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        txn_strb[0] = 8'h0F;
        run_txn(1'b1, BASE, MLEN1, AXI_BURST_INCR, -1);
        run_txn(1'b0, BASE, MLEN1, AXI_BURST_INCR, -1);

        // INCR wrap at the top of the RAM, and a FIXED burst.
        run_txn(1'b0, BASE + 64'(MEM_WORDS - 2) * 64'd8, MLEN8, AXI_BURST_INCR, -1);
        run_txn(1'b0, BASE + 64'd40, MLEN4, AXI_BURST_FIXED, -1);

        // Reset during the second beat of an eight-beat read, then a clean read.
        run_txn(1'b0, BASE + 64'd64, MLEN8, AXI_BURST_INCR, 1);
        run_txn(1'b0, BASE + 64'd64, MLEN1, AXI_BURST_INCR, -1);

        // Beyond the RAM: out-of-range or aliasing depending on the build.
        run_txn(1'b0, BASE + MEM_BYTES, MLEN1, AXI_BURST_INCR, -1);
        fill_random(8'hFF);
        run_txn(1'b1, BASE + MEM_BYTES, MLEN2, AXI_BURST_INCR, -1);
        run_txn(1'b0, BASE, MLEN2, AXI_BURST_INCR, -1);

        // Random traffic.
        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                a = BASE + MEM_BYTES + 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd8;
            end else if (r == 1) begin
                a = BASE - 64'd8;
            end else begin
                a = BASE + 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd8
                    + 64'($urandom_range(0, 7));
            end
            fill_random(8'($urandom_range(0, 255)));
            run_txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 0) ? AXI_BURST_FIXED : AXI_BURST_INCR, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
